// File: rtl/knn_vote_selector.sv
// K-nearest-neighbour vote: keeps the K smallest (distance, type) results sorted, then majority-votes their class.
// Build option KNN_TIE_NEAREST_EN: count ties go to the class of the nearest retained neighbour (one extra select cycle).
module knn_vote_selector #(
  parameter int K  = 3,
  parameter int T  = 8,
  parameter int NC = 4,
  parameter int W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         distance_valid,
  input  logic [W-1:0] distance,
  input  logic [W-1:0] data_type,
  output logic         busy,
  output logic         class_valid,
  output logic [W-1:0] class_out,
  output logic [W-1:0] nearest_distance
);

  localparam int HW   = $clog2(K + 1);
  localparam int CNTW = $clog2(T + 1);
  localparam int CW   = (NC > 1) ? $clog2(NC) : 1;
  localparam int IW   = $clog2(((K > NC) ? K : NC) + 2);
`ifdef KNN_TIE_NEAREST_EN
  localparam int LAST_SEL = NC;
`else
  localparam int LAST_SEL = NC - 1;
`endif

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_VOTE_COUNT, S_VOTE_SELECT, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_dist [K];
  logic [W-1:0]    r_type [K];
  logic [K-1:0]    r_vld;
  logic [CNTW-1:0] r_count;
  logic [HW-1:0]   r_hist [NC];
  logic [IW-1:0]   r_idx;
  logic [HW-1:0]   r_best_cnt;
  logic [CW-1:0]   r_best_cls;
  logic            r_class_vld;
  logic [W-1:0]    r_class;
  logic [W-1:0]    r_nearest;

  logic [W-1:0]    w_dist_nxt [K];
  logic [W-1:0]    w_type_nxt [K];
  logic [K-1:0]    w_vld_nxt;
  logic            w_seen, w_gt, w_pv, w_accept;
  logic [W-1:0]    w_pd, w_pt, w_sel_type;
  logic            w_sel_vld;
  logic [HW-1:0]   w_bin;

  assign busy             = (r_state == S_COLLECT) || (r_state == S_VOTE_COUNT) || (r_state == S_VOTE_SELECT);
  assign class_valid      = r_class_vld;
  assign class_out        = r_class;
  assign nearest_distance = r_nearest;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (start) w_state_nxt = S_COLLECT;
        else if (distance_valid) begin
          w_accept = 1'b1;
          if (r_count == CNTW'(T - 1)) w_state_nxt = S_VOTE_COUNT;
        end
      end
      S_VOTE_COUNT: begin
        if (start) w_state_nxt = S_COLLECT;
        else if (r_idx == IW'(K - 1)) w_state_nxt = S_VOTE_SELECT;
      end
      S_VOTE_SELECT: begin
        if (start) w_state_nxt = S_COLLECT;
        else if (r_idx == IW'(LAST_SEL)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = start ? S_COLLECT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Invalid slots compare as "greater" so the sorted list always fills from the front.
  always_comb begin
    w_seen = 1'b0;
    w_gt   = 1'b0;
    w_pd   = '0;
    w_pt   = '0;
    w_pv   = 1'b0;
    for (int i = 0; i < K; i++) begin
      w_gt          = !r_vld[i] || (r_dist[i] > distance);
      w_dist_nxt[i] = r_dist[i];
      w_type_nxt[i] = r_type[i];
      w_vld_nxt[i]  = r_vld[i];
      if (w_gt) begin
        if (!w_seen) begin
          w_dist_nxt[i] = distance;
          w_type_nxt[i] = data_type;
          w_vld_nxt[i]  = 1'b1;
        end else begin
          w_dist_nxt[i] = w_pd;
          w_type_nxt[i] = w_pt;
          w_vld_nxt[i]  = w_pv;
        end
      end
      w_seen = w_seen | w_gt;
      w_pd   = r_dist[i];
      w_pt   = r_type[i];
      w_pv   = r_vld[i];
    end
  end

  always_comb begin
    w_sel_type = '0;
    w_sel_vld  = 1'b0;
    w_bin      = '0;
    for (int i = 0; i < K; i++) begin
      if (r_idx == IW'(i)) begin
        w_sel_type = r_type[i];
        w_sel_vld  = r_vld[i];
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (r_idx == IW'(c)) w_bin = r_hist[c];
    end
  end

`ifdef KNN_TIE_NEAREST_EN
  logic          w_near_hit;
  logic [CW-1:0] w_near_cls;

  // Walk from the back so the lowest-index tied entry wins.
  always_comb begin
    w_near_hit = 1'b0;
    w_near_cls = '0;
    for (int i = K - 1; i >= 0; i--) begin
      for (int c = 0; c < NC; c++) begin
        if (r_vld[i] && (r_type[i] == W'(c)) && (r_hist[c] == r_best_cnt)) begin
          w_near_hit = 1'b1;
          w_near_cls = CW'(c);
        end
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        r_dist[i] <= '1;
        r_type[i] <= '0;
      end
      for (int c = 0; c < NC; c++) r_hist[c] <= '0;
      r_vld       <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_best_cnt  <= '0;
      r_best_cls  <= '0;
      r_class_vld <= 1'b0;
      r_class     <= '0;
      r_nearest   <= '0;
    end else begin
      r_class_vld <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_class   <= W'(r_best_cls);
        r_nearest <= r_vld[0] ? r_dist[0] : '1;
      end
      if (start) begin
        for (int i = 0; i < K; i++) begin
          r_dist[i] <= '1;
          r_type[i] <= '0;
        end
        for (int c = 0; c < NC; c++) r_hist[c] <= '0;
        r_vld      <= '0;
        r_count    <= '0;
        r_idx      <= '0;
        r_best_cnt <= '0;
        r_best_cls <= '0;
      end else begin
        case (r_state)
          S_COLLECT: begin
            if (w_accept) begin
              for (int i = 0; i < K; i++) begin
                r_dist[i] <= w_dist_nxt[i];
                r_type[i] <= w_type_nxt[i];
              end
              r_vld   <= w_vld_nxt;
              r_count <= r_count + CNTW'(1);
            end
          end
          S_VOTE_COUNT: begin
            for (int c = 0; c < NC; c++) begin
              if (w_sel_vld && (w_sel_type == W'(c))) r_hist[c] <= r_hist[c] + HW'(1);
            end
            r_idx <= (r_idx == IW'(K - 1)) ? '0 : r_idx + IW'(1);
          end
          S_VOTE_SELECT: begin
            if (r_idx < IW'(NC)) begin
              if (w_bin > r_best_cnt) begin
                r_best_cnt <= w_bin;
                r_best_cls <= CW'(r_idx);
              end
            end
`ifdef KNN_TIE_NEAREST_EN
            else if (w_near_hit) begin
              r_best_cls <= w_near_cls;
            end
`endif
            r_idx <= r_idx + IW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_knn_vote_selector.sv
// Directed bench for knn_vote_selector (K=3, T=8, NC=4, W=32).
module tb_knn_vote_selector;

`ifdef KNN_TIE_NEAREST_EN
  localparam int LAT = 9;
  localparam int TIE_CLS = 2;
`else
  localparam int LAT = 8;
  localparam int TIE_CLS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        distance_valid = 1'b0;
  logic [31:0] distance = '0;
  logic [31:0] data_type = '0;
  logic        busy, class_valid;
  logic [31:0] class_out, nearest_distance;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int vd [8];
  int vt [8];

  knn_vote_selector #(.K(3), .T(8), .NC(4), .W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .distance_valid(distance_valid),
    .distance(distance), .data_type(data_type), .busy(busy),
    .class_valid(class_valid), .class_out(class_out), .nearest_distance(nearest_distance)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (class_valid === 1'b1) pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int d, input int t);
    distance_valid = 1'b1;
    distance = 32'(d);
    data_type = 32'(t);
    tick();
    distance_valid = 1'b0;
  endtask

  task automatic collect_and_check(input string tag, input int exp_cls, input int exp_near);
    int cyc;
    int p0;
    for (int i = 0; i < 8; i++) send(vd[i], vt[i]);
    p0 = pulses;
    cyc = 0;
    while (class_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(LAT));
    chk({tag, "_class"}, class_out, 32'(exp_cls));
    chk({tag, "_nearest"}, nearest_distance, 32'(exp_near));
    tick();
    chk({tag, "_pulse_width"}, 32'(class_valid), 32'd0);
    chk({tag, "_pulse_count"}, 32'(pulses - p0), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic run8(input string tag, input int exp_cls, input int exp_near);
    pulse_start();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    collect_and_check(tag, exp_cls, exp_near);
  endtask

  initial begin
    int p0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(class_valid), 32'd0);
    chk("rst_class", class_out, 32'd0);
    chk("rst_nearest", nearest_distance, 32'd0);
    rst = 1'b0;
    tick();

    // distance_valid in IDLE must not be collected
    p0 = pulses;
    for (int i = 0; i < 3; i++) send(1, 3);
    repeat (15) tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pulses", 32'(pulses - p0), 32'd0);

    vd = '{50, 10, 40, 30, 20, 60, 70, 80};
    vt = '{0, 1, 2, 1, 1, 3, 0, 2};
    run8("majority", 1, 10);
    chk("majority_list0", dut.r_dist[0], 32'd10);
    chk("majority_list1", dut.r_dist[1], 32'd20);
    chk("majority_list2", dut.r_dist[2], 32'd30);

    vd = '{5, 6, 7, 100, 100, 100, 100, 100};
    vt = '{2, 3, 0, 1, 1, 1, 1, 1};
    run8("tie3", TIE_CLS, 5);

    vd = '{7, 7, 7, 7, 7, 7, 7, 7};
    vt = '{3, 3, 1, 0, 0, 0, 0, 0};
    run8("equal", 3, 7);
    chk("equal_type0", dut.r_type[0], 32'd3);
    chk("equal_type1", dut.r_type[1], 32'd3);
    chk("equal_type2", dut.r_type[2], 32'd1);

    vd = '{1, 2, 3, 50, 50, 50, 50, 50};
    vt = '{9, 1, 2, 0, 0, 0, 0, 0};
    run8("oor", 1, 1);

    // Restart: second start coincides with a sample that must be dropped
    p0 = pulses;
    pulse_start();
    for (int i = 0; i < 4; i++) send(i + 1, 0);
    start = 1'b1;
    distance_valid = 1'b1;
    distance = 32'd0;
    data_type = 32'd3;
    tick();
    start = 1'b0;
    distance_valid = 1'b0;
    chk("restart_no_early_pulse", 32'(pulses - p0), 32'd0);
    vd = '{10, 11, 12, 13, 14, 15, 16, 17};
    vt = '{2, 2, 2, 2, 2, 2, 2, 2};
    collect_and_check("restart", 2, 10);

    // Reset while voting aborts the run
    p0 = pulses;
    pulse_start();
    vd = '{3, 4, 5, 6, 7, 8, 9, 10};
    vt = '{1, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) send(vd[i], vt[i]);
    tick();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_class", class_out, 32'd0);
    chk("midrst_nearest", nearest_distance, 32'd0);
    repeat (20) tick();
    chk("midrst_no_pulse", 32'(pulses - p0), 32'd0);
    chk("midrst_class_hold", class_out, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
